// File: rtl/calib_master_fsm_if.sv
// Calibration handshake bundle between the master sequencer and the far-side slave/adapter.
// The master modport is the sequencer's view; the slave modport is the far side's view.
interface calib_master_fsm_if #(
  parameter int TOTAL_CHNL_NUM = 24
);
  logic                      start;
  logic [TOTAL_CHNL_NUM-1:0] fs_mac_rdy;
  logic [TOTAL_CHNL_NUM-1:0] sl_rx_dcc_dll_lock_req;
  logic [TOTAL_CHNL_NUM-1:0] sl_tx_dcc_dll_lock_req;
  logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en;
  logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en;
  logic                      ms_conf_done;
  logic [TOTAL_CHNL_NUM-1:0] ms_rx_dcc_dll_lock_req;
  logic [TOTAL_CHNL_NUM-1:0] ms_tx_dcc_dll_lock_req;
  logic [TOTAL_CHNL_NUM-1:0] ns_adapter_rstn;
  logic                      calib_done;
  logic                      calib_fail;
  logic [3:0]                retry_cnt;

  modport master (
    input  start, fs_mac_rdy, sl_rx_dcc_dll_lock_req, sl_tx_dcc_dll_lock_req,
           sl_tx_transfer_en, sl_rx_transfer_en,
    output ms_conf_done, ms_rx_dcc_dll_lock_req, ms_tx_dcc_dll_lock_req,
           ns_adapter_rstn, calib_done, calib_fail, retry_cnt
  );

  modport slave (
    output start, fs_mac_rdy, sl_rx_dcc_dll_lock_req, sl_tx_dcc_dll_lock_req,
           sl_tx_transfer_en, sl_rx_transfer_en,
    input  ms_conf_done, ms_rx_dcc_dll_lock_req, ms_tx_dcc_dll_lock_req,
           ns_adapter_rstn, calib_done, calib_fail, retry_cnt
  );
endinterface

// File: rtl/calib_master_fsm.sv
// AIB calibration master sequencer: conf-done, MAC wait, DCC/DLL lock request, ack wait, link watch.
// Define CALIB_MASTER_TIMEOUT_EN to enable the timeout / retry-limit / FAIL engine.
module calib_master_fsm #(
  parameter int TOTAL_CHNL_NUM = 24,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3,
  parameter int BACKOFF_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  calib_master_fsm_if.master bus
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_CONF, S_WAIT_MAC, S_REQ, S_WAIT_ACK, S_DONE, S_BACKOFF, S_FAIL
  } state_t;

  state_t                    state_q, state_d, retry_tgt;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [3:0]                retry_q, retry_d;
  logic                      conf_q, done_q, fail_q;
  logic [TOTAL_CHNL_NUM-1:0] req_q;
  logic                      mac_all, link_up, ack_all, tmo_hit;

  assign mac_all = &bus.fs_mac_rdy;
  assign link_up = (&bus.sl_tx_transfer_en) & (&bus.sl_rx_transfer_en);
  assign ack_all = link_up & (&bus.sl_rx_dcc_dll_lock_req) & (&bus.sl_tx_dcc_dll_lock_req);

`ifdef CALIB_MASTER_TIMEOUT_EN
  assign tmo_hit   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign retry_tgt = (retry_q < 4'(MAX_RETRY)) ? S_BACKOFF : S_FAIL;
`else
  assign tmo_hit   = 1'b0;
  assign retry_tgt = S_BACKOFF;
`endif

  // Success is tested before the timeout so a coincident ack wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.start) state_d = S_CONF;
      S_CONF:     state_d = S_WAIT_MAC;
      S_WAIT_MAC: if (mac_all) state_d = S_REQ;
                  else if (tmo_hit) state_d = retry_tgt;
      // Acks already present skip WAIT_ACK so calib_done lands one edge after the reqs.
      S_REQ:      state_d = ack_all ? S_DONE : S_WAIT_ACK;
      S_WAIT_ACK: if (ack_all) state_d = S_DONE;
                  else if (tmo_hit) state_d = retry_tgt;
      S_DONE:     if (!link_up) state_d = retry_tgt;
      S_BACKOFF:  if (cnt_q == CW'(BACKOFF_CYCLES - 1)) state_d = S_CONF;
      S_FAIL:     if (bus.start) state_d = S_CONF;
      default:    state_d = S_IDLE;
    endcase
  end

  // One counter serves both the wait-state timeout and the backoff hold; it clears on any state change.
  always_comb begin
    cnt_d   = '0;
    retry_d = retry_q;
    if (state_d == state_q) begin
      if (state_q == S_BACKOFF) cnt_d = cnt_q + CW'(1);
`ifdef CALIB_MASTER_TIMEOUT_EN
      else if (state_q == S_WAIT_MAC || state_q == S_WAIT_ACK) cnt_d = cnt_q + CW'(1);
`endif
    end
`ifdef CALIB_MASTER_TIMEOUT_EN
    if (state_q == S_FAIL && state_d == S_CONF) retry_d = '0;
    else if (state_d == S_BACKOFF && state_q != S_BACKOFF && retry_q != 4'hF)
      retry_d = retry_q + 4'd1;
`else
    retry_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      conf_q  <= 1'b0;
      req_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      conf_q  <= (state_d != S_IDLE) && (state_d != S_FAIL);
      req_q   <= {TOTAL_CHNL_NUM{state_d inside {S_REQ, S_WAIT_ACK, S_DONE}}};
      done_q  <= (state_d == S_DONE);
      fail_q  <= (state_d == S_FAIL);
    end
  end

  assign bus.ms_conf_done           = conf_q;
  assign bus.ms_rx_dcc_dll_lock_req = req_q;
  assign bus.ms_tx_dcc_dll_lock_req = req_q;
  assign bus.ns_adapter_rstn        = req_q;
  assign bus.calib_done             = done_q;
  assign bus.calib_fail             = fail_q;
  assign bus.retry_cnt              = retry_q;
endmodule
